batch_reverser: RTL and testbench

- Ping-pong batch buffer that turns the forward-ordered sample stream into time-reversed batches of DEPTH samples.
- Its output feeds the backward (anti-causal) recursion path, so that path runs the same recursion as the forward path but in the other time direction.
- out_first drives the backward recursion's rst/reset-value load at the start of every reversed batch.
- Throughput is rate-matched: one sample out per sample in once the first batch is full.

---
 rtl/batch_reverser.sv | 148 ++++++++++++++
 tb/tb_batch_reverser.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/batch_reverser.sv
// batch_reverser
// Ping-pong batch buffer that turns a forward-ordered sample stream into
// time-reversed batches of DEPTH samples. It feeds the backward
// (anti-causal) recursion path, which reuses the forward recursion with
// time running the other way. out_first marks where that path must reload
// its initial value.
//
// One bank is filled while the other, already complete, bank is read
// backwards. Reads are rate-matched to writes, so after the first batch
// there is one sample out for every sample in.
//
// Optional feature: define BATCH_REVERSER_DRAIN_EN to add a 'drain' input.
// drain lets the final batch be flushed when no more input arrives.
//
// Parameters:
//   DEPTH   samples per batch (>= 2)
//   DATA_W  bits per sample
//   CNT_W   width of the bank address counters
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_data    forward-ordered sample
//   in_valid   in_data valid this cycle
//   drain      (BATCH_REVERSER_DRAIN_EN only) read without writing
//   out_data   reversed sample, registered
//   out_valid  out_data valid
//   out_first  first sample of a reversed batch (original index DEPTH-1)
//   out_last   last sample of a reversed batch (original index 0)
module batch_reverser #(
  parameter int DEPTH  = 64,
  parameter int DATA_W = 64,
  parameter int CNT_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
`ifdef BATCH_REVERSER_DRAIN_EN
  input  logic              drain,
`endif
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_first,
  output logic              out_last
);

  typedef enum logic [1:0] {
    FILL,
    STREAM,
    EMPTY
  } state_t;

  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(DEPTH - 1);

  state_t            state;
  logic              wr_bank;
  logic              rd_bank;
  logic [CNT_W-1:0]  wr_cnt;
  logic [CNT_W-1:0]  rd_cnt;
  logic [DATA_W-1:0] mem [2][DEPTH];

  logic drain_req;
  logic do_read;
  logic swap;
  logic rd_bottom;

  // Without the drain feature, a read can only ever be triggered by an
  // incoming sample, so the drain request is tied off.
`ifdef BATCH_REVERSER_DRAIN_EN
  assign drain_req = drain;
`else
  assign drain_req = 1'b0;
`endif

  assign rd_bank = ~wr_bank;

  // A read happens whenever a complete bank is present and either a new
  // sample arrives or we are being drained. A swap happens on the sample
  // that completes the write bank. drain has no effect while in_valid is
  // high, because that cycle already reads.
  always_comb begin
    do_read   = 1'b0;
    swap      = 1'b0;
    rd_bottom = 1'b0;
    do_read   = (state == STREAM) && (in_valid || drain_req);
    swap      = in_valid && (wr_cnt == CNT_TOP);
    rd_bottom = (rd_cnt == '0);
  end

  // Sample storage. The two banks are never reset; stale contents cannot
  // leak out because a bank is only read after it has been completely
  // rewritten since the last reset.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      mem[wr_bank][wr_cnt] <= in_data;
    end
  end

  // Read side and bank control. The read always addresses the bank that
  // was complete at the start of the cycle, so on a swap cycle the old
  // bank's index-0 sample (out_last) goes out. The very next read then
  // starts the new bank at DEPTH-1 (out_first) with no bubble. Reads and
  // writes pair up 1:1 while streaming, so rd_cnt hits 0 exactly on a swap.
  // Only draining can exhaust a bank early, which parks the FSM in EMPTY
  // until the write side completes another bank. The swap branch comes
  // last so that it overrides the read-side rd_cnt/state updates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
      wr_bank   <= 1'b0;
      wr_cnt    <= '0;
      rd_cnt    <= CNT_TOP;
      state     <= FILL;
    end else begin
      if (do_read) begin
        out_data  <= mem[rd_bank][rd_cnt];
        out_valid <= 1'b1;
        out_first <= (rd_cnt == CNT_TOP);
        out_last  <= rd_bottom;
        if (!rd_bottom) begin
          rd_cnt <= rd_cnt - 1'b1;
        end else if (!swap) begin
          state <= EMPTY;
        end
      end else begin
        out_valid <= 1'b0;
        out_first <= 1'b0;
        out_last  <= 1'b0;
      end

      if (in_valid) begin
        if (swap) begin
          wr_cnt  <= '0;
          wr_bank <= ~wr_bank;
          rd_cnt  <= CNT_TOP;
          state   <= STREAM;
        end else begin
          wr_cnt <= wr_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_batch_reverser.sv
// tb_batch_reverser
// Self-checking bench for batch_reverser with DEPTH=4. A behavioural
// reference model runs alongside the stimulus driver. For every driven
// cycle it pushes the expected output to a scoreboard queue, and each
// test task pops and compares after the following clock edge.
// Build with BATCH_REVERSER_DRAIN_EN to also exercise the drain feature.
module tb_batch_reverser;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 16;

  typedef struct packed {
    logic              v;
    logic              f;
    logic              l;
    logic [DATA_W-1:0] d;
  } exp_t;

  typedef struct {
    logic              v;
    logic              dr;
    logic [DATA_W-1:0] d;
  } stim_t;

  logic              clk;
  logic              rst;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
`ifdef BATCH_REVERSER_DRAIN_EN
  logic              drain;
`endif
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_first;
  logic              out_last;

  exp_t sb[$];

  logic [DATA_W-1:0] m_wbuf [DEPTH];
  logic [DATA_W-1:0] m_rbuf [DEPTH];
  int                m_wcnt;
  int                m_ridx;
  bit                m_stream;

  int n_cmp;
  int n_bad;

  batch_reverser #(
    .DEPTH (DEPTH),
    .DATA_W(DATA_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
`ifdef BATCH_REVERSER_DRAIN_EN
    .drain    (drain),
`endif
    .out_data (out_data),
    .out_valid(out_valid),
    .out_first(out_first),
    .out_last (out_last)
  );

  // Free-running 10-time-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one cycle of stimulus at the falling edge and advances the
  // reference model. The model keeps whole batches as arrays: a completed
  // write batch is copied into the read batch, which is then replayed from
  // its highest index down.
  task automatic applyStimulus(input logic v, input logic [DATA_W-1:0] d, input logic dr);
    exp_t e;
    bit   drain_eff;
    @(negedge clk);
    in_valid = v;
    in_data  = d;
`ifdef BATCH_REVERSER_DRAIN_EN
    drain     = dr;
    drain_eff = dr;
`else
    drain_eff = 1'b0;
`endif
    e = '0;
    if (m_stream && (v || drain_eff)) begin
      e.v = 1'b1;
      e.d = m_rbuf[m_ridx];
      e.f = (m_ridx == DEPTH - 1);
      e.l = (m_ridx == 0);
      if (m_ridx == 0) m_stream = 1'b0;
      else m_ridx--;
    end
    if (v) begin
      m_wbuf[m_wcnt] = d;
      m_wcnt++;
      if (m_wcnt == DEPTH) begin
        m_rbuf   = m_wbuf;
        m_wcnt   = 0;
        m_ridx   = DEPTH - 1;
        m_stream = 1'b1;
      end
    end
    sb.push_back(e);
  endtask

  // Puts the DUT and the model back into their reset state.
  task automatic pulseReset();
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = '0;
`ifdef BATCH_REVERSER_DRAIN_EN
    drain = 1'b0;
`endif
    rst = 1'b1;
    m_wcnt   = 0;
    m_ridx   = DEPTH - 1;
    m_stream = 1'b0;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Outputs must be idle while reset is held.
  task automatic test_reset();
    logic [DATA_W+2:0] obs;
    @(negedge clk);
    rst = 1'b1;
    #1;
    obs = {out_valid, out_first, out_last, out_data};
    n_cmp++;
    if (obs !== '0) begin
      n_bad++;
      $display("[TB] FAIL reset: got v=%0b f=%0b l=%0b d=%0d, want all zero",
               out_valid, out_first, out_last, out_data);
    end
    pulseReset();
  endtask

  // Shared body for the table-driven tests: drive each entry, then pop and
  // compare the expectation after the next rising edge.
  task automatic test_sequence(input string name, input stim_t st[$]);
    exp_t e;
    exp_t obs;
    foreach (st[i]) begin
      applyStimulus(st[i].v, st[i].d, st[i].dr);
      @(posedge clk);
      #1;
      e   = sb.pop_front();
      obs = {out_valid, out_first, out_last, out_valid ? out_data : {DATA_W{1'b0}}};
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("[TB] FAIL %s[%0d]: got v=%0b f=%0b l=%0b d=%0d, want v=%0b f=%0b l=%0b d=%0d",
                 name, i, obs.v, obs.f, obs.l, obs.d, e.v, e.f, e.l, e.d);
      end
    end
  endtask

  // First batch, 1..4: nothing comes out.
  task automatic test_fill();
    stim_t st[$];
    for (int i = 1; i <= DEPTH; i++) st.push_back('{1'b1, 1'b0, DATA_W'(i)});
    test_sequence("fill", st);
  endtask

  // Second batch, 5..8: produces 4,3,2,1 with first/last flags.
  task automatic test_first_batch();
    stim_t st[$];
    for (int i = 5; i <= 8; i++) st.push_back('{1'b1, 1'b0, DATA_W'(i)});
    test_sequence("first_batch", st);
  endtask

  // Third batch, 9..12: 8,7,6,5 follow 1 with no bubble.
  task automatic test_back_to_back();
    stim_t st[$];
    for (int i = 9; i <= 12; i++) st.push_back('{1'b1, 1'b0, DATA_W'(i)});
    test_sequence("back_to_back", st);
  endtask

  // Gaps of 1..3 idle cycles between inputs 5..12.
  task automatic test_gaps();
    stim_t st[$];
    pulseReset();
    for (int i = 1; i <= 4; i++) st.push_back('{1'b1, 1'b0, DATA_W'(i)});
    for (int i = 5; i <= 12; i++) begin
      int g;
      g = int'($urandom_range(1, 3));
      for (int k = 0; k < g; k++) st.push_back('{1'b0, 1'b0, DATA_W'(16'hdead)});
      st.push_back('{1'b1, 1'b0, DATA_W'(i)});
    end
    st.push_back('{1'b0, 1'b0, DATA_W'(0)});
    test_sequence("gaps", st);
  endtask

  // Reset after input 6, then 20..31: stale 2,1 must never appear.
  task automatic test_mid_reset();
    stim_t st[$];
    logic [DATA_W+2:0] obs;
    pulseReset();
    for (int i = 1; i <= 6; i++) st.push_back('{1'b1, 1'b0, DATA_W'(i)});
    test_sequence("pre_reset", st);
    @(negedge clk);
    rst = 1'b1;
    #1;
    obs = {out_valid, out_first, out_last, out_data};
    n_cmp++;
    if (obs !== '0) begin
      n_bad++;
      $display("[TB] FAIL mid_reset: got v=%0b f=%0b l=%0b d=%0d, want all zero",
               out_valid, out_first, out_last, out_data);
    end
    pulseReset();
    st.delete();
    for (int i = 20; i <= 31; i++) st.push_back('{1'b1, 1'b0, DATA_W'(i)});
    test_sequence("post_reset", st);
  endtask

  // Random valid pattern, with random drain when the feature is built in.
  task automatic test_random();
    stim_t st[$];
    pulseReset();
    for (int i = 0; i < 120; i++) begin
      st.push_back('{($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0),
                     DATA_W'($urandom)});
    end
    test_sequence("random", st);
  endtask

`ifdef BATCH_REVERSER_DRAIN_EN
  // Flushing the final batch: 1..8, six drain cycles, then more input.
  // drain is also asserted during FILL, during EMPTY and together with
  // in_valid, where it must have no effect.
  task automatic test_drain();
    stim_t st[$];
    pulseReset();
    st.push_back('{1'b0, 1'b1, DATA_W'(0)});
    for (int i = 1; i <= 8; i++) st.push_back('{1'b1, (i == 6), DATA_W'(i)});
    for (int k = 0; k < 6; k++) st.push_back('{1'b0, 1'b1, DATA_W'(0)});
    for (int i = 9; i <= 14; i++) st.push_back('{1'b1, (i == 10), DATA_W'(i)});
    for (int k = 0; k < 3; k++) st.push_back('{1'b0, 1'b1, DATA_W'(0)});
    test_sequence("drain", st);
  endtask
`endif

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
`ifdef BATCH_REVERSER_DRAIN_EN
    drain = 1'b0;
`endif
    m_wcnt   = 0;
    m_ridx   = DEPTH - 1;
    m_stream = 1'b0;

    test_reset();
    test_fill();
    test_first_batch();
    test_back_to_back();
    test_gaps();
    test_mid_reset();
`ifdef BATCH_REVERSER_DRAIN_EN
    test_drain();
`endif
    test_random();

    $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
